multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multi-cycle control FSM for the RISC-V core, the successor to the single-cycle opcode decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, holds the same datapath control set (ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp, Branch, Jump, CurrFlag) valid per state, and handshakes with instruction and data memories that have variable latency. It sits between the instruction register and the shared multi-cycle datapath and traps on illegal opcodes or bus timeouts.

## Interface
- ALUOP_W, 3: ALUOp width; must be ≥ 3.
- MEM_TIMEOUT, 16: maximum wait cycles for a memory ready before a trap; range 1–255.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- Opcode  in  7  instruction[6:0] from the IR; sampled in DECODE
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data access request
- IRWrite  out  1  load the IR this cycle
- PCWrite  out  1  update the PC this cycle
- ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, CurrFlag  out  1 each  datapath controls; same meaning as the single-cycle decoder
- ALUOp  out  ALUOP_W  000 add, 001 branch compare, 010 R-type funct, 011 I-type funct, 100 pass operand B (LUI)
- trap  out  1  controller halted
- trap_cause  out  2  01 illegal opcode, 10 memory timeout, 00 none

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. State and op_q (latched opcode) are registers. All outputs are Moore functions of (state, op_q).
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: imem_req=1. When imem_ready=1, IRWrite=1 and PCWrite=1 (PC+4 path), and the next state is DECODE. Otherwise stay in FETCH.
- DECODE: op_q ← Opcode. Opcodes:
  - Legal: 0110011 R, 0000011 LW, 0100011 SW, 1100011 BR, 0010011 I-ALU, 1101111 JAL, 1100111 JALR, 0110111 LUI.
  - Illegal opcode: next state TRAP, trap_cause=01.
  - Legal opcode: next state EXEC.
- EXEC, controls by opcode:
  - R: ALUOp=010.
  - I-ALU: ALUSrc=1, ALUOp=011.
  - LW/SW: ALUSrc=1, ALUOp=000.
  - BR: ALUOp=001, Branch=1 (the datapath gates PCWrite with the zero flag).
  - JAL: ALUSrc=1, ALUOp=000, Jump=1, PCWrite=1.
  - JALR: ALUSrc=1, ALUOp=000, CurrFlag=1, PCWrite=1.
  - LUI: ALUSrc=1, ALUOp=100.
- After EXEC:
  - LW/SW go to MEM.
  - BR goes to FETCH.
  - All other opcodes go to WB.
- MEM: dmem_req=1, with MemRead=1 (LW) or MemWrite=1 (SW). When dmem_ready=1, LW goes to WB and SW goes to FETCH.
- WB: RegWrite=1. MemtoReg=1 only for LW. JAL/JALR write the link value. Next state is FETCH.
- Wait counter (8 bits):
  - Clears on entry to FETCH or MEM.
  - Increments each cycle req=1 and ready=0.
  - When the count equals MEM_TIMEOUT with ready still 0, next state is TRAP and trap_cause=10.
  - A ready arriving in the same cycle as the timeout condition wins; no trap is taken.
- TRAP: trap=1, all other outputs 0, no requests. Exit only by reset.
- Ready inputs are ignored in any state that does not assert the corresponding req.

## Timing
- Reset asserted: state=IDLE, op_q=0, counter=0, trap_cause=00; every output is 0 asynchronously.
- Reset mid-instruction aborts the instruction immediately; no partial writes are issued after reset assertion.
- Latency with zero-wait memory (imem_ready high on first FETCH cycle), in cycles:
  - BR: 3.
  - R, I-ALU, LUI, JAL, JALR, SW: 4.
  - LW: 5.
- Each wait cycle adds one.
- First FETCH occurs 1 cycle after reset release (IDLE lasts exactly 1 cycle).
- req stays high continuously until ready is sampled high; it drops in the cycle after.
- IRWrite and PCWrite in FETCH are single-cycle pulses, coincident with the imem_ready cycle.

## Configuration
- CTRL_PERF_CNT_EN:
  - Defined: adds outputs cycle_cnt[31:0] and instret_cnt[31:0], both reset to 0.
    - cycle_cnt increments every cycle outside IDLE/TRAP.
    - instret_cnt increments on each transition into FETCH from EXEC, MEM or WB.
    - Both wrap modulo 2^32.
  - Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- R-type 0110011, imem_ready tied 1 → FETCH, DECODE, EXEC (ALUOp=010), WB (RegWrite=1); back in FETCH 4 cycles after the first FETCH.
- LW 0000011, dmem_ready delayed 3 cycles → dmem_req high for 4 cycles with MemRead=1, then WB with MemtoReg=1 and RegWrite=1; total 8 cycles.
- JAL 1101111 then JALR 1100111 → EXEC shows Jump=1, PCWrite=1 for JAL, and CurrFlag=1, PCWrite=1 for JALR; WB RegWrite=1 for both.
- Opcode 1111111 → TRAP after DECODE, trap=1, trap_cause=01, outputs stay 0 for 20 cycles; reset low then high → IDLE, then FETCH.
- MEM_TIMEOUT=4, SW with dmem_ready held 0 → trap_cause=10 after 4 wait cycles; repeat with ready on the 4th cycle → no trap, returns to FETCH.
- With CTRL_PERF_CNT_EN, 3 back-to-back BR instructions at zero wait → instret_cnt=3, cycle_cnt=9.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V control FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP); `CTRL_PERF_CNT_EN adds cycle/instret counters.
// Zero-wait latency BR 3, ALU/JAL/JALR/LUI/SW 4, LW 5 cycles; req held until ready, trap after MEM_TIMEOUT wait cycles.
module multicycle_controller #(
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         Opcode,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               imem_req,
    output logic               dmem_req,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               ALUSrc,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               Branch,
    output logic               Jump,
    output logic               CurrFlag,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               trap,
    output logic [1:0]         trap_cause
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]        cycle_cnt,
    output logic [31:0]        instret_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [ALUOP_W-1:0] AOP_ADD  = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] AOP_BR   = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] AOP_RTYP = ALUOP_W'(3'b010);
    localparam logic [ALUOP_W-1:0] AOP_ITYP = ALUOP_W'(3'b011);
    localparam logic [ALUOP_W-1:0] AOP_PASS = ALUOP_W'(3'b100);

    // The wait that would make the count reach MEM_TIMEOUT is the last one tolerated.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [6:0] op_q;
    logic [7:0] wait_cnt;
    logic [1:0] cause_nxt;
    logic       wait_hit;
    logic       op_legal;

    assign wait_hit = (wait_cnt == WAIT_LAST);
    assign op_legal = (Opcode == OP_R)   || (Opcode == OP_LW)  || (Opcode == OP_SW)
                   || (Opcode == OP_BR)  || (Opcode == OP_I)   || (Opcode == OP_JAL)
                   || (Opcode == OP_JALR)|| (Opcode == OP_LUI);

    always_comb begin
        state_nxt = state;
        cause_nxt = trap_cause;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        ALUSrc    = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Branch    = 1'b0;
        Jump      = 1'b0;
        CurrFlag  = 1'b0;
        ALUOp     = AOP_ADD;
        trap      = 1'b0;
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    state_nxt = DECODE;
                end else if (wait_hit) begin
                    state_nxt = TRAP;
                    cause_nxt = 2'b10;
                end
            end
            DECODE: begin
                if (op_legal) begin
                    state_nxt = EXEC;
                end else begin
                    state_nxt = TRAP;
                    cause_nxt = 2'b01;
                end
            end
            EXEC: begin
                state_nxt = WB;
                case (op_q)
                    OP_R:  ALUOp = AOP_RTYP;
                    OP_I: begin
                        ALUSrc = 1'b1;
                        ALUOp  = AOP_ITYP;
                    end
                    OP_LW, OP_SW: begin
                        ALUSrc    = 1'b1;
                        state_nxt = MEM;
                    end
                    OP_BR: begin
                        ALUOp     = AOP_BR;
                        Branch    = 1'b1;
                        state_nxt = FETCH;
                    end
                    OP_JAL: begin
                        ALUSrc  = 1'b1;
                        Jump    = 1'b1;
                        PCWrite = 1'b1;
                    end
                    OP_JALR: begin
                        ALUSrc   = 1'b1;
                        CurrFlag = 1'b1;
                        PCWrite  = 1'b1;
                    end
                    OP_LUI: begin
                        ALUSrc = 1'b1;
                        ALUOp  = AOP_PASS;
                    end
                    default: state_nxt = WB;
                endcase
            end
            MEM: begin
                dmem_req = 1'b1;
                MemRead  = (op_q == OP_LW);
                MemWrite = (op_q == OP_SW);
                if (dmem_ready) begin
                    state_nxt = (op_q == OP_LW) ? WB : FETCH;
                end else if (wait_hit) begin
                    state_nxt = TRAP;
                    cause_nxt = 2'b10;
                end
            end
            WB: begin
                RegWrite  = 1'b1;
                MemtoReg  = (op_q == OP_LW);
                state_nxt = FETCH;
            end
            TRAP: trap = 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            op_q       <= 7'd0;
            wait_cnt   <= 8'd0;
            trap_cause <= 2'b00;
        end else begin
            state      <= state_nxt;
            trap_cause <= cause_nxt;
            if (state == DECODE) begin
                op_q <= Opcode;
            end
            // Any state change restarts the count, covering every entry into FETCH or MEM.
            if (state_nxt != state) begin
                wait_cnt <= 8'd0;
            end else if ((imem_req && !imem_ready) || (dmem_req && !dmem_ready)) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt   <= 32'd0;
            instret_cnt <= 32'd0;
        end else begin
            if (state != IDLE && state != TRAP) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (state_nxt == FETCH && (state == EXEC || state == MEM || state == WB)) begin
                instret_cnt <= instret_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed latency table, hand sequences, and random instructions vs a phase-level model.
// DUT runs with MEM_TIMEOUT=4; inputs change 1 time unit after posedge, outputs sampled on negedge.
module tb_multicycle_controller;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] Opcode = 7'd0;
    logic       imem_ready = 1'b0;
    logic       dmem_ready = 1'b0;
    logic       imem_req, dmem_req, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite;
    logic       MemRead, MemWrite, Branch, Jump, CurrFlag, trap;
    logic [2:0] ALUOp;
    logic [1:0] trap_cause;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    always #5 clk = ~clk;

    multicycle_controller #(.ALUOP_W(3), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .imem_req(imem_req), .dmem_req(dmem_req),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
        .Jump(Jump), .CurrFlag(CurrFlag), .ALUOp(ALUOp), .trap(trap),
        .trap_cause(trap_cause)
`ifdef CTRL_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    typedef struct packed {
        logic imem_req, dmem_req, irw, pcw, alusrc, m2r, rw, mr, mw, br, jmp, cf;
        logic [2:0] aluop;
        logic trap;
        logic [1:0] cause;
    } ov_t;

    typedef struct {
        logic ir;
        logic dr;
        logic [6:0] opc;
        ov_t o;
    } cyc_t;

    typedef struct {
        string nm;
        logic [6:0] op;
        int iw;
        int dw;
        int lat;
        int mcyc;
        logic [1:0] cause;
    } dir_t;

    localparam logic [6:0] R = 7'b0110011, LW = 7'b0000011, SW = 7'b0100011, BR = 7'b1100011;
    localparam logic [6:0] IA = 7'b0010011, JAL = 7'b1101111, JALR = 7'b1100111, LUI = 7'b0110111;

    ov_t  got;
    cyc_t q[$];
    int   checks = 0;
    int   errors = 0;

    assign got = {imem_req, dmem_req, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite,
                  MemRead, MemWrite, Branch, Jump, CurrFlag, ALUOp, trap, trap_cause};

    task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, g, e);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom);
    endfunction

    task automatic push(input logic ir, input logic dr, input logic [6:0] opc, input ov_t o);
        cyc_t c;
        c.ir = ir; c.dr = dr; c.opc = opc; c.o = o;
        q.push_back(c);
    endtask

    task automatic trap_tail(input logic [1:0] cause);
        ov_t o;
        for (int i = 0; i < 4; i++) begin
            o = '0; o.trap = 1'b1; o.cause = cause;
            push(rb(), rb(), rop(), o);
        end
    endtask

    // Phase-level model: one instruction expanded into its expected cycle list.
    task automatic build(input logic [6:0] op, input int iw, input int dw, output bit trapped);
        ov_t o;
        int  nw;
        trapped = 1'b0;
        nw = (iw < TMO) ? iw : TMO;
        for (int i = 0; i < nw; i++) begin
            o = '0; o.imem_req = 1'b1;
            push(1'b0, rb(), rop(), o);
        end
        if (iw >= TMO) begin
            trap_tail(2'b10); trapped = 1'b1; return;
        end
        o = '0; o.imem_req = 1'b1; o.irw = 1'b1; o.pcw = 1'b1;
        push(1'b1, rb(), rop(), o);
        o = '0;
        push(rb(), rb(), op, o);
        if (!(op inside {R, LW, SW, BR, IA, JAL, JALR, LUI})) begin
            trap_tail(2'b01); trapped = 1'b1; return;
        end
        o = '0;
        case (op)
            R:       o.aluop = 3'd2;
            IA:      begin o.alusrc = 1'b1; o.aluop = 3'd3; end
            LW, SW:  o.alusrc = 1'b1;
            BR:      begin o.aluop = 3'd1; o.br = 1'b1; end
            JAL:     begin o.alusrc = 1'b1; o.jmp = 1'b1; o.pcw = 1'b1; end
            JALR:    begin o.alusrc = 1'b1; o.cf = 1'b1; o.pcw = 1'b1; end
            default: begin o.alusrc = 1'b1; o.aluop = 3'd4; end
        endcase
        push(rb(), rb(), rop(), o);
        if (op == LW || op == SW) begin
            nw = (dw < TMO) ? dw : TMO;
            for (int i = 0; i <= nw; i++) begin
                if (i == nw && dw >= TMO) begin
                    trap_tail(2'b10); trapped = 1'b1; return;
                end
                o = '0; o.dmem_req = 1'b1; o.mr = (op == LW); o.mw = (op == SW);
                push(rb(), (i == nw), rop(), o);
            end
        end
        if (op != BR && op != SW) begin
            o = '0; o.rw = 1'b1; o.m2r = (op == LW);
            push(rb(), rb(), rop(), o);
        end
    endtask

    task automatic run_q(input string nm);
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            imem_ready = c.ir; dmem_ready = c.dr; Opcode = c.opc;
            @(negedge clk);
            chk(nm, got, c.o);
            @(posedge clk); #1;
        end
    endtask

    // Leaves the DUT in its first FETCH cycle, 1 time unit after the edge.
    task automatic do_reset();
        reset = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    // Reactive driver: ready after iw/dw wait cycles; stops on next FETCH or on trap.
    task automatic drive_dir(input logic [6:0] op, input int iw, input int dw,
                             output int lat, output int mcyc, output logic [1:0] cause);
        int fw, dwc;
        bit fetched;
        fw = 0; dwc = 0; fetched = 1'b0; lat = -1; mcyc = 0; cause = 2'b00;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (trap) begin lat = cyc; cause = trap_cause; break; end
            if (fetched && imem_req) begin lat = cyc; cause = trap_cause; break; end
            Opcode = op;
            imem_ready = imem_req && (fw == iw);
            dmem_ready = dmem_req && (dwc == dw);
            @(negedge clk);
            if (IRWrite) fetched = 1'b1;
            if (imem_req) fw++;
            if (dmem_req) begin dwc++; mcyc++; end
            @(posedge clk); #1;
        end
    endtask

    dir_t tbl[15];
    logic [6:0] legal_ops[8] = '{R, LW, SW, BR, IA, JAL, JALR, LUI};
    logic [6:0] bad_ops[4] = '{7'h7F, 7'h00, 7'b0010111, 7'b1110011};

    initial begin
        int lat, mc;
        logic [1:0] cs;
        bit tr;

        tbl[0]  = '{"r_zero",     R,    0, 0, 4, 0, 2'b00};
        tbl[1]  = '{"ialu_zero",  IA,   0, 0, 4, 0, 2'b00};
        tbl[2]  = '{"lui_zero",   LUI,  0, 0, 4, 0, 2'b00};
        tbl[3]  = '{"jal_zero",   JAL,  0, 0, 4, 0, 2'b00};
        tbl[4]  = '{"jalr_zero",  JALR, 0, 0, 4, 0, 2'b00};
        tbl[5]  = '{"br_zero",    BR,   0, 0, 3, 0, 2'b00};
        tbl[6]  = '{"sw_zero",    SW,   0, 0, 4, 1, 2'b00};
        tbl[7]  = '{"lw_zero",    LW,   0, 0, 5, 1, 2'b00};
        tbl[8]  = '{"lw_dwait3",  LW,   0, 3, 8, 4, 2'b00};
        tbl[9]  = '{"r_iwait2",   R,    2, 0, 6, 0, 2'b00};
        tbl[10] = '{"sw_rdy_4th", SW,   0, 3, 7, 4, 2'b00};
        tbl[11] = '{"br_iwait3",  BR,   3, 0, 6, 0, 2'b00};
        tbl[12] = '{"sw_timeout", SW,   0, 9, 7, 4, 2'b10};
        tbl[13] = '{"illegal",    7'h7F,0, 0, 2, 0, 2'b01};
        tbl[14] = '{"if_timeout", R,    9, 0, 4, 0, 2'b10};

        // Reset state and IDLE length.
        #2;
        chk("reset_outputs", got, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("idle_outputs", got, 32'd0);
        @(posedge clk); #1;
        chk("first_fetch_req", imem_req, 1'b1);

        foreach (tbl[i]) begin
            drive_dir(tbl[i].op, tbl[i].iw, tbl[i].dw, lat, mc, cs);
            chk({tbl[i].nm, "_lat"}, lat, tbl[i].lat);
            chk({tbl[i].nm, "_memcyc"}, mc, tbl[i].mcyc);
            chk({tbl[i].nm, "_cause"}, cs, tbl[i].cause);
            if (tbl[i].cause != 2'b00) do_reset();
        end

        // Illegal opcode: trap holds for 20 cycles, then reset recovers.
        drive_dir(7'h7F, 0, 0, lat, mc, cs);
        for (int i = 0; i < 20; i++) begin
            imem_ready = rb(); dmem_ready = rb(); Opcode = rop();
            @(negedge clk);
            chk("trap_hold", got, 32'h4 | 32'h1);
            @(posedge clk); #1;
        end
        do_reset();
        chk("post_trap_fetch", imem_req, 1'b1);
        chk("post_trap_cause", trap_cause, 2'b00);

        // Reset in JAL's EXEC cycle drops every output immediately.
        Opcode = JAL; imem_ready = 1'b1;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        @(posedge clk); #1;
        chk("jal_exec_pcwrite", PCWrite, 1'b1);
        #2 reset = 1'b0;
        #1 chk("midreset_outputs", got, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_idle", got, 32'd0);
        @(posedge clk); #1;

`ifdef CTRL_PERF_CNT_EN
        do_reset();
        for (int i = 0; i < 3; i++) drive_dir(BR, 0, 0, lat, mc, cs);
        chk("perf_cycle", cycle_cnt, 32'd9);
        chk("perf_instret", instret_cnt, 32'd3);
`endif

        // Random instruction stream against the phase model.
        do_reset();
        for (int n = 0; n < 250; n++) begin
            logic [6:0] op;
            int iw, dw;
            op = ($urandom_range(0, 11) == 0) ? bad_ops[$urandom_range(0, 3)]
                                              : legal_ops[$urandom_range(0, 7)];
            iw = ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, 3);
            dw = ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, 3);
            build(op, iw, dw, tr);
            run_q("rand_cycle");
            if (tr) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
